// File: rtl/lcd_bcd_formatter.sv
// lcd_bcd_formatter: serial double-dabble conversion of six 7-bit values into twelve LCD ASCII bytes
module lcd_bcd_formatter #(
  parameter bit BLANK_LZ    = 1'b1,
  parameter int REFRESH_DIV = 0
) (
  input  logic       Sys_Clk,
  input  logic       Sys_Rst_n,
  input  logic       update_req,
  input  logic [6:0] cnt_a,
  input  logic [6:0] cnt_b,
  input  logic [6:0] cnt_c,
  input  logic [6:0] ivl_a,
  input  logic [6:0] ivl_b,
  input  logic [6:0] ivl_c,
  output logic [7:0] YIMA_DATA1,
  output logic [7:0] YIMA_DATA2,
  output logic [7:0] YIMA_DATA3,
  output logic [7:0] YIMA_DATA4,
  output logic [7:0] YIMA_DATA5,
  output logic [7:0] YIMA_DATA6,
  output logic [7:0] YIMA_DATA7,
  output logic [7:0] YIMA_DATA8,
  output logic [7:0] YIMA_DATA9,
  output logic [7:0] YIMA_DATA10,
  output logic [7:0] YIMA_DATA11,
  output logic [7:0] YIMA_DATA12,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} state_t;
  state_t      state, state_nx;
  logic [6:0]  snap [6];
  logic [2:0]  idx;
  logic [2:0]  sh_cnt;
  logic [18:0] sr;
  logic [18:0] sr_nx;
  logic [7:0]  shadow [12];
  logic [7:0]  yima [12];
  logic        pending;
  logic [31:0] ref_cnt;
  logic        tick;
  logic        req;
  logic        capture;
  logic [7:0]  tens_byte;
  logic [7:0]  units_byte;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  assign tick = (REFRESH_DIV != 0) && (ref_cnt == 32'(REFRESH_DIV - 1));
  assign req = update_req | tick;
  assign capture = (state == IDLE && req) || (state == COMMIT && (pending || req));
  assign sr_nx = {adj(sr[18:15]), adj(sr[14:11]), adj(sr[10:7]), sr[6:0]} << 1;
  assign tens_byte = (sr[18:15] != 4'd0) ? 8'h2D :
                     (BLANK_LZ && sr[14:11] == 4'd0) ? 8'hA0 : {4'h3, sr[14:11]};
  assign units_byte = (sr[18:15] != 4'd0) ? 8'h2D : {4'h3, sr[10:7]};
  assign YIMA_DATA1  = yima[0];
  assign YIMA_DATA2  = yima[1];
  assign YIMA_DATA3  = yima[2];
  assign YIMA_DATA4  = yima[3];
  assign YIMA_DATA5  = yima[4];
  assign YIMA_DATA6  = yima[5];
  assign YIMA_DATA7  = yima[6];
  assign YIMA_DATA8  = yima[7];
  assign YIMA_DATA9  = yima[8];
  assign YIMA_DATA10 = yima[9];
  assign YIMA_DATA11 = yima[10];
  assign YIMA_DATA12 = yima[11];
  // free-running auto-refresh divider, wraps at REFRESH_DIV-1
  always_ff @(posedge Sys_Clk) begin
    if (!Sys_Rst_n) ref_cnt <= '0;
    else if (REFRESH_DIV != 0) ref_cnt <= tick ? '0 : ref_cnt + 32'd1;
  end
  // sequencer next-state: LOAD, 7 shifts, STORE per value, then one COMMIT
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? LOAD : IDLE;
      LOAD:    state_nx = SHIFT;
      SHIFT:   state_nx = (sh_cnt == 3'd6) ? STORE : SHIFT;
      STORE:   state_nx = (idx == 3'd5) ? COMMIT : LOAD;
      COMMIT:  state_nx = (pending || req) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register, conversion datapath, shadow capture and atomic output commit
  always_ff @(posedge Sys_Clk) begin
    if (!Sys_Rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      idx     <= '0;
      sh_cnt  <= '0;
      sr      <= '0;
      for (int i = 0; i < 12; i++) begin
        shadow[i] <= 8'hA0;
        yima[i]   <= 8'hA0;
      end
    end else begin
      state <= state_nx;
      busy  <= state_nx != IDLE;
      done  <= state == COMMIT;
      if (state == COMMIT) pending <= 1'b0;
      else if (state != IDLE && req) pending <= 1'b1;
      if (capture) begin
        snap <= '{cnt_a, ivl_a, cnt_b, ivl_b, cnt_c, ivl_c};
        idx  <= '0;
      end
      if (state == LOAD) begin
        sr     <= {12'd0, snap[idx]};
        sh_cnt <= '0;
      end
      if (state == SHIFT) begin
        sr     <= sr_nx;
        sh_cnt <= sh_cnt + 3'd1;
      end
      if (state == STORE) begin
        shadow[{idx, 1'b0}] <= tens_byte;
        shadow[{idx, 1'b1}] <= units_byte;
        idx <= idx + 3'd1;
      end
      if (state == COMMIT) yima <= shadow;
    end
  end
endmodule

// File: tb/tb_lcd_bcd_formatter.sv
// tb_lcd_bcd_formatter: randomized self-checking bench against a decimal-arithmetic reference model
module tb_lcd_bcd_formatter;
  logic Sys_Clk = 1'b0;
  logic Sys_Rst_n = 1'b0;
  logic update_req = 1'b0;
  logic no_req = 1'b0;
  logic [6:0] cnt_a, cnt_b, cnt_c, ivl_a, ivl_b, ivl_c;
  logic [7:0] d0 [12];
  logic [7:0] d1 [12];
  logic [7:0] d2 [12];
  logic busy0, done0, busy1, done1, busy2, done2;
  int vals [6];
  int n_chk = 0;
  int n_pass = 0;
  localparam logic [95:0] BLANK_FRAME = {12{8'hA0}};
  logic [95:0] prev0 = BLANK_FRAME;
  logic [95:0] prev1 = BLANK_FRAME;

  always #5 Sys_Clk = ~Sys_Clk;

  lcd_bcd_formatter #(.BLANK_LZ(1'b1), .REFRESH_DIV(0)) u_dut0 (
    .Sys_Clk(Sys_Clk), .Sys_Rst_n(Sys_Rst_n), .update_req(update_req),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .ivl_a(ivl_a), .ivl_b(ivl_b), .ivl_c(ivl_c),
    .YIMA_DATA1(d0[0]), .YIMA_DATA2(d0[1]), .YIMA_DATA3(d0[2]), .YIMA_DATA4(d0[3]),
    .YIMA_DATA5(d0[4]), .YIMA_DATA6(d0[5]), .YIMA_DATA7(d0[6]), .YIMA_DATA8(d0[7]),
    .YIMA_DATA9(d0[8]), .YIMA_DATA10(d0[9]), .YIMA_DATA11(d0[10]), .YIMA_DATA12(d0[11]),
    .busy(busy0), .done(done0));

  lcd_bcd_formatter #(.BLANK_LZ(1'b0), .REFRESH_DIV(0)) u_dut1 (
    .Sys_Clk(Sys_Clk), .Sys_Rst_n(Sys_Rst_n), .update_req(update_req),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .ivl_a(ivl_a), .ivl_b(ivl_b), .ivl_c(ivl_c),
    .YIMA_DATA1(d1[0]), .YIMA_DATA2(d1[1]), .YIMA_DATA3(d1[2]), .YIMA_DATA4(d1[3]),
    .YIMA_DATA5(d1[4]), .YIMA_DATA6(d1[5]), .YIMA_DATA7(d1[6]), .YIMA_DATA8(d1[7]),
    .YIMA_DATA9(d1[8]), .YIMA_DATA10(d1[9]), .YIMA_DATA11(d1[10]), .YIMA_DATA12(d1[11]),
    .busy(busy1), .done(done1));

  lcd_bcd_formatter #(.BLANK_LZ(1'b1), .REFRESH_DIV(100)) u_dut2 (
    .Sys_Clk(Sys_Clk), .Sys_Rst_n(Sys_Rst_n), .update_req(no_req),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .ivl_a(ivl_a), .ivl_b(ivl_b), .ivl_c(ivl_c),
    .YIMA_DATA1(d2[0]), .YIMA_DATA2(d2[1]), .YIMA_DATA3(d2[2]), .YIMA_DATA4(d2[3]),
    .YIMA_DATA5(d2[4]), .YIMA_DATA6(d2[5]), .YIMA_DATA7(d2[6]), .YIMA_DATA8(d2[7]),
    .YIMA_DATA9(d2[8]), .YIMA_DATA10(d2[9]), .YIMA_DATA11(d2[10]), .YIMA_DATA12(d2[11]),
    .busy(busy2), .done(done2));

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] pair(input int v, input bit blank);
    if (v >= 100) return 16'h2D2D;
    return {(blank && v / 10 == 0) ? 8'hA0 : 8'(8'h30 + v / 10), 8'(8'h30 + v % 10)};
  endfunction

  function automatic logic [95:0] model(input bit blank);
    logic [95:0] f = '0;
    for (int i = 0; i < 6; i++) f = {f[79:0], pair(vals[i], blank)};
    return f;
  endfunction

  function automatic logic [95:0] frame(input logic [7:0] d [12]);
    logic [95:0] f = '0;
    for (int i = 0; i < 12; i++) f = {f[87:0], d[i]};
    return f;
  endfunction

  task automatic apply;
    {cnt_a, ivl_a, cnt_b, ivl_b, cnt_c, ivl_c} =
      {7'(vals[0]), 7'(vals[1]), 7'(vals[2]), 7'(vals[3]), 7'(vals[4]), 7'(vals[5])};
  endtask

  task automatic step;
    @(posedge Sys_Clk);
    #1;
  endtask

  task automatic rand_vals;
    for (int i = 0; i < 6; i++) vals[i] = int'($urandom_range(127));
  endtask

  task automatic seq(input int second_at, input int change_at, input int new_a);
    logic [95:0] f1_0, f1_1, f2_0, f2_1, e0, e1;
    int last;
    apply;
    f1_0 = model(1'b1);
    f1_1 = model(1'b0);
    f2_0 = f1_0;
    f2_1 = f1_1;
    last = (second_at > 0) ? 110 : 55;
    update_req = 1'b1;
    step;
    update_req = 1'b0;
    for (int n = 1; n <= last + 2; n++) begin
      update_req = (n == second_at);
      if (n == change_at) begin
        vals[0] = new_a;
        apply;
      end
      if (n == 55) begin
        f2_0 = model(1'b1);
        f2_1 = model(1'b0);
      end
      step;
      e0 = (n < 55) ? prev0 : (second_at > 0 && n >= 110) ? f2_0 : f1_0;
      e1 = (n < 55) ? prev1 : (second_at > 0 && n >= 110) ? f2_1 : f1_1;
      check("done0", done0, n == 55 || (second_at > 0 && n == 110));
      check("done1", done1, n == 55 || (second_at > 0 && n == 110));
      check("busy0", busy0, n < last);
      check("frame0", frame(d0), e0);
      check("frame1", frame(d1), e1);
    end
    update_req = 1'b0;
    prev0 = (second_at > 0) ? f2_0 : f1_0;
    prev1 = (second_at > 0) ? f2_1 : f1_1;
  endtask

  initial begin
    rand_vals;
    apply;
    Sys_Rst_n = 1'b0;
    step;
    step;
    Sys_Rst_n = 1'b1;
    check("rst_frame0", frame(d0), BLANK_FRAME);
    check("rst_frame1", frame(d1), BLANK_FRAME);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    for (int k = 0; k < 360; k++) begin
      step;
      check("refresh_done", done2, k >= 154 && (k - 154) % 100 == 0);
      check("refresh_frame", frame(d2), (k < 154) ? BLANK_FRAME : model(1'b1));
    end
    check("idle_frame0", frame(d0), BLANK_FRAME);
    vals = '{7, 42, 0, 99, 10, 5};
    seq(0, 0, 0);
    check("spec_frame", frame(d0), 96'hA037_3432_A030_3939_3130_A035);
    vals[0] = 100;
    vals[5] = 127;
    seq(0, 0, 0);
    vals[0] = 99;
    vals[2] = 3;
    seq(0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      rand_vals;
      seq(0, 0, 0);
    end
    rand_vals;
    vals[0] = 7;
    seq(20, 10, 55);
    rand_vals;
    seq(55, 0, 0);
    rand_vals;
    apply;
    update_req = 1'b1;
    step;
    update_req = 1'b0;
    for (int n = 1; n < 30; n++) step;
    Sys_Rst_n = 1'b0;
    step;
    Sys_Rst_n = 1'b1;
    check("abort_frame0", frame(d0), BLANK_FRAME);
    check("abort_frame1", frame(d1), BLANK_FRAME);
    check("abort_busy0", busy0, 1'b0);
    check("abort_done0", done0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      step;
      check("abort_no_done", done0, 1'b0);
      check("abort_idle", busy0, 1'b0);
    end
    prev0 = BLANK_FRAME;
    prev1 = BLANK_FRAME;
    rand_vals;
    seq(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
